// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and its surroundings (decode redirects, instruction memory).
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface pc_sequencer_if;
  logic [27:0] JumpTarget28;
  logic        Jump;
  logic        Branch;
  logic [31:0] BranchOffset;
  logic        JumpReg;
  logic [31:0] RegTarget;
  logic        Stall;
  logic        IMemReady;
  logic        IMemValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Redirected;
  logic        MisalignErr;

  modport master (
    input  JumpTarget28, Jump, Branch, BranchOffset, JumpReg, RegTarget, Stall, IMemReady,
    output IMemValid, PC, PCPlus4, Redirected, MisalignErr
  );

  modport slave (
    output JumpTarget28, Jump, Branch, BranchOffset, JumpReg, RegTarget, Stall, IMemReady,
    input  IMemValid, PC, PCPlus4, Redirected, MisalignErr
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: holds the PC, hands it to instruction memory, and picks the next PC from redirects.
// Optional macro PC_SEQ_MISALIGN_CHECK_EN: flag misaligned register jumps and force their low bits to zero.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           Clk,
  input  logic           Reset_n,
  pc_sequencer_if.master bus
);

  typedef enum logic {S_BOOT, S_FETCH} state_t;

  state_t      state_reg, state_next;
  logic        fetch_valid;
  logic        advance;
  logic        redir_any;
  logic [31:0] pc_plus4;
  logic [31:0] reg_target_eff;
  logic [31:0] redir_target;
  logic [31:0] pc_reg, pc_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic        redirected_reg, redirected_next;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_reg <= S_BOOT;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    fetch_valid = 1'b0;
    unique case (state_reg)
      S_BOOT:  state_next = S_FETCH;
      S_FETCH: begin
        fetch_valid = 1'b1;
        state_next  = S_FETCH;
      end
      default: state_next = S_BOOT;
    endcase
  end

`ifdef PC_SEQ_MISALIGN_CHECK_EN
  logic misalign_reg, misalign_next;

  assign reg_target_eff = {bus.RegTarget[31:2], 2'b00};

  always_comb begin
    misalign_next = misalign_reg;
    if (fetch_valid && bus.JumpReg && (bus.RegTarget[1:0] != 2'b00))
      misalign_next = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) misalign_reg <= 1'b0;
    else          misalign_reg <= misalign_next;
  end

  assign bus.MisalignErr = misalign_reg;
`else
  assign reg_target_eff  = bus.RegTarget;
  assign bus.MisalignErr = 1'b0;
`endif

  assign pc_plus4  = pc_reg + 32'd4;
  assign advance   = fetch_valid & bus.IMemReady & ~bus.Stall;
  // Redirect requests only count once fetching has started.
  assign redir_any = fetch_valid & (bus.JumpReg | bus.Jump | bus.Branch);

  always_comb begin
    redir_target = pc_plus4 + bus.BranchOffset;
    if (bus.JumpReg)   redir_target = reg_target_eff;
    else if (bus.Jump) redir_target = {pc_plus4[31:28], bus.JumpTarget28};
  end

  always_comb begin
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    redirected_next  = 1'b0;
    if (advance) begin
      pend_valid_next = 1'b0;
      redirected_next = redir_any | pend_valid_reg;
      if (redir_any)           pc_next = redir_target;
      else if (pend_valid_reg) pc_next = pend_target_reg;
      else                     pc_next = pc_plus4;
    end else if (redir_any) begin
      // Hold the newest redirect until memory accepts the current PC.
      pend_valid_next  = 1'b1;
      pend_target_next = redir_target;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= 32'h0000_0000;
      redirected_reg  <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      redirected_reg  <= redirected_next;
    end
  end

  assign bus.IMemValid  = fetch_valid;
  assign bus.PC         = pc_reg;
  assign bus.PCPlus4    = pc_plus4;
  assign bus.Redirected = redirected_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: linear step sequence with hand-computed expectations.
// Expectations for the misalignment case follow whether PC_SEQ_MISALIGN_CHECK_EN is defined.
module tb_pc_sequencer;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_redirects();
    bus.Jump    = 1'b0;
    bus.Branch  = 1'b0;
    bus.JumpReg = 1'b0;
  endtask

  initial begin
    bus.JumpTarget28 = '0;
    bus.BranchOffset = '0;
    bus.RegTarget    = '0;
    bus.Stall        = 1'b0;
    bus.IMemReady    = 1'b0;
    clear_redirects();

    // Reset state
    tick();
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_valid", {31'b0, bus.IMemValid}, 32'h0);
    chk("rst_redir", {31'b0, bus.Redirected}, 32'h0);
    chk("rst_misalign", {31'b0, bus.MisalignErr}, 32'h0);

    // Release reset; a Jump during boot must be ignored
    Reset_n = 1'b1;
    bus.IMemReady = 1'b1;
    bus.Jump = 1'b1;
    bus.JumpTarget28 = 28'h0000800;
    #1;
    chk("boot_valid", {31'b0, bus.IMemValid}, 32'h0);
    tick();
    bus.Jump = 1'b0;
    chk("fetch_valid", {31'b0, bus.IMemValid}, 32'h1);
    chk("seq_pc0", bus.PC, 32'h0);
    tick();
    chk("seq_pc4", bus.PC, 32'h4);
    tick();
    chk("seq_pc8", bus.PC, 32'h8);
    chk("seq_noredir", {31'b0, bus.Redirected}, 32'h0);

    // Register jump to 0x1000_0040, then J-type jump keeps upper nibble
    bus.JumpReg = 1'b1;
    bus.RegTarget = 32'h1000_0040;
    tick();
    clear_redirects();
    chk("jr_pc", bus.PC, 32'h1000_0040);
    chk("jr_redir", {31'b0, bus.Redirected}, 32'h1);
    bus.Jump = 1'b1;
    bus.JumpTarget28 = 28'h0000120;
    tick();
    clear_redirects();
    chk("j_pc", bus.PC, 32'h1000_0120);
    chk("j_redir", {31'b0, bus.Redirected}, 32'h1);
    tick();
    chk("j_after_pc", bus.PC, 32'h1000_0124);
    chk("j_after_redir", {31'b0, bus.Redirected}, 32'h0);
    chk("pcplus4", bus.PCPlus4, 32'h1000_0128);

    // Branch while memory not ready: held, then pending target taken
    bus.JumpReg = 1'b1;
    bus.RegTarget = 32'h0000_0100;
    tick();
    clear_redirects();
    chk("br_setup_pc", bus.PC, 32'h100);
    bus.IMemReady = 1'b0;
    bus.Branch = 1'b1;
    bus.BranchOffset = 32'hFFFF_FFF0;
    tick();
    chk("br_hold1", bus.PC, 32'h100);
    chk("br_hold_redir", {31'b0, bus.Redirected}, 32'h0);
    tick();
    chk("br_hold2", bus.PC, 32'h100);
    clear_redirects();
    bus.IMemReady = 1'b1;
    tick();
    chk("br_pend_pc", bus.PC, 32'h0000_00F4);
    chk("br_pend_redir", {31'b0, bus.Redirected}, 32'h1);
    tick();
    chk("br_after_pc", bus.PC, 32'h0000_00F8);
    chk("br_after_redir", {31'b0, bus.Redirected}, 32'h0);

    // Jump and Branch together: Jump wins
    bus.Jump = 1'b1;
    bus.JumpTarget28 = 28'h0000200;
    bus.Branch = 1'b1;
    bus.BranchOffset = 32'h0000_0040;
    tick();
    clear_redirects();
    chk("jb_pc", bus.PC, 32'h0000_0200);
    chk("jb_redir", {31'b0, bus.Redirected}, 32'h1);
    tick();
    chk("jb_after_pc", bus.PC, 32'h0000_0204);
    chk("jb_after_redir", {31'b0, bus.Redirected}, 32'h0);

    // Newer pending redirect overwrites older one
    bus.IMemReady = 1'b0;
    bus.Jump = 1'b1;
    bus.JumpTarget28 = 28'h0000300;
    tick();
    clear_redirects();
    bus.Branch = 1'b1;
    bus.BranchOffset = 32'h0000_0010;
    tick();
    clear_redirects();
    bus.IMemReady = 1'b1;
    tick();
    chk("pend_newest_pc", bus.PC, 32'h0000_0218);

    // Same-cycle redirect beats a pending one, and pending is then cleared
    bus.IMemReady = 1'b0;
    bus.Jump = 1'b1;
    bus.JumpTarget28 = 28'h0000400;
    tick();
    clear_redirects();
    bus.IMemReady = 1'b1;
    bus.JumpReg = 1'b1;
    bus.RegTarget = 32'h0000_0500;
    tick();
    clear_redirects();
    chk("same_cycle_pc", bus.PC, 32'h0000_0500);
    tick();
    chk("pend_cleared_pc", bus.PC, 32'h0000_0504);

    // Stall with memory ready: PC held
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.PC, 32'h0000_0504);
      chk("stall_valid", {31'b0, bus.IMemValid}, 32'h1);
    end
    bus.Stall = 1'b0;
    tick();
    chk("unstall_pc", bus.PC, 32'h0000_0508);

    // Sequential wrap-around
    bus.JumpReg = 1'b1;
    bus.RegTarget = 32'hFFFF_FFFC;
    tick();
    clear_redirects();
    chk("wrap_top", bus.PC, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus.PCPlus4, 32'h0);
    tick();
    chk("wrap_pc", bus.PC, 32'h0);
    chk("wrap_redir", {31'b0, bus.Redirected}, 32'h0);

    // Misaligned register jump
    bus.JumpReg = 1'b1;
    bus.RegTarget = 32'h0000_2003;
    tick();
    clear_redirects();
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    chk("mis_pc", bus.PC, 32'h0000_2000);
    chk("mis_flag", {31'b0, bus.MisalignErr}, 32'h1);
    tick();
    chk("mis_sticky", {31'b0, bus.MisalignErr}, 32'h1);
    chk("mis_next_pc", bus.PC, 32'h0000_2004);
`else
    chk("mis_pc", bus.PC, 32'h0000_2003);
    chk("mis_flag", {31'b0, bus.MisalignErr}, 32'h0);
    tick();
    chk("mis_sticky", {31'b0, bus.MisalignErr}, 32'h0);
    chk("mis_next_pc", bus.PC, 32'h0000_2007);
`endif

    // Reset mid-operation with a pending redirect
    bus.IMemReady = 1'b0;
    bus.Branch = 1'b1;
    bus.BranchOffset = 32'h0000_0100;
    tick();
    clear_redirects();
    Reset_n = 1'b0;
    #1;
    chk("arst_pc", bus.PC, 32'h0);
    chk("arst_valid", {31'b0, bus.IMemValid}, 32'h0);
    chk("arst_misalign", {31'b0, bus.MisalignErr}, 32'h0);
    tick();
    Reset_n = 1'b1;
    bus.IMemReady = 1'b1;
    #1;
    chk("arst_boot_valid", {31'b0, bus.IMemValid}, 32'h0);
    tick();
    chk("arst_fetch_pc", bus.PC, 32'h0);
    chk("arst_fetch_valid", {31'b0, bus.IMemValid}, 32'h1);
    tick();
    chk("arst_discard_pc", bus.PC, 32'h0000_0004);
    chk("arst_redir", {31'b0, bus.Redirected}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
